// File: rtl/i2c_pwm_slave.sv
// i2c_pwm_slave: eight-channel LED PWM controller with an I2C slave register port.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   scl  - I2C clock from the master
//   sda  - open-drain I2C data; this block drives only 0 or Z
//   led  - heartbeat square wave
//   leds - PWM outputs, bit n from duty register n
module i2c_pwm_slave #(
    parameter logic [6:0] I2C_ADDR = 7'h28,
    parameter int         HB_DIV   = 12000000,
    parameter int         PWM_DIV  = 47
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    output logic       led,
    output logic [7:0] leds
);

    localparam int HBW = (HB_DIV / 2 > 1) ? $clog2(HB_DIV / 2) : 1;
    localparam int PW  = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    localparam logic [7:0] DUTY_RST [8] =
        '{8'd1, 8'd20, 8'd40, 8'd60, 8'd80, 8'd100, 8'd200, 8'd255};

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RX_ADDR  = 3'd1;
    localparam logic [2:0] ACK_ADDR = 3'd2;
    localparam logic [2:0] RX_BYTE  = 3'd3;
    localparam logic [2:0] ACK_RX   = 3'd4;
    localparam logic [2:0] TX_BYTE  = 3'd5;
    localparam logic [2:0] ACK_TX   = 3'd6;

    // Heartbeat
    logic [HBW-1:0] hb_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hb_cnt <= '0;
            led    <= 1'b0;
        end else if (hb_cnt == HBW'(HB_DIV / 2 - 1)) begin
            hb_cnt <= '0;
            led    <= ~led;
        end else begin
            hb_cnt <= hb_cnt + 1'b1;
        end
    end

    // Register file and I2C state
    logic [7:0] duty [8];
    logic [7:0] act  [8];
    logic [2:0] ptr;
    logic [2:0] state;
    logic [3:0] bit_cnt;
    logic [7:0] shreg;
    logic       sda_oe;
    logic       rw;
    logic       first;

    // PWM: leds follows pcnt by one step so each step compares the
    // value pcnt held before it advanced.
    logic [PW-1:0] pre;
    logic [7:0]    pcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre  <= '0;
            pcnt <= 8'd0;
            leds <= 8'd0;
            for (int i = 0; i < 8; i++) act[i] <= DUTY_RST[i];
        end else if (pre == PW'(PWM_DIV - 1)) begin
            pre  <= '0;
            pcnt <= pcnt + 8'd1;
            for (int i = 0; i < 8; i++) leds[i] <= (pcnt < act[i]);
            if (pcnt == 8'hff) begin
                for (int i = 0; i < 8; i++) act[i] <= duty[i];
            end
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // Synchronizers; bus idles high
    logic [2:0] scl_s;
    logic [2:0] sda_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_s <= 3'b111;
            sda_s <= 3'b111;
        end else begin
            scl_s <= {scl_s[1:0], scl};
            sda_s <= {sda_s[1:0], sda};
        end
    end

    logic sda_in;
    logic scl_rise;
    logic scl_fall;
    logic start_c;
    logic stop_c;

    assign sda_in   = sda_s[1];
    assign scl_rise = scl_s[1] & ~scl_s[2];
    assign scl_fall = ~scl_s[1] & scl_s[2];
    assign start_c  = scl_s[1] & scl_s[2] & ~sda_s[1] & sda_s[2];
    assign stop_c   = scl_s[1] & scl_s[2] & sda_s[1] & ~sda_s[2];

    assign sda = sda_oe ? 1'b0 : 1'bz;

    // bit_cnt reaches 8 on the last data rise; in ACK states 8 means
    // "ACK not yet driven" and 9 means "ACK slot in progress".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= 4'd0;
            shreg   <= 8'd0;
            sda_oe  <= 1'b0;
            rw      <= 1'b0;
            first   <= 1'b0;
            ptr     <= 3'd0;
            for (int i = 0; i < 8; i++) duty[i] <= DUTY_RST[i];
        end else if (start_c) begin
            state   <= RX_ADDR;
            bit_cnt <= 4'd0;
            sda_oe  <= 1'b0;
        end else if (stop_c) begin
            state  <= IDLE;
            sda_oe <= 1'b0;
        end else begin
            case (state)
                RX_ADDR: if (scl_rise) begin
                    shreg   <= {shreg[6:0], sda_in};
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        rw    <= sda_in;
                        state <= (shreg[6:0] == I2C_ADDR) ? ACK_ADDR : IDLE;
                    end
                end
                ACK_ADDR: if (scl_fall) begin
                    if (bit_cnt == 4'd8) begin
                        sda_oe  <= 1'b1;
                        bit_cnt <= 4'd9;
                    end else begin
                        bit_cnt <= 4'd0;
                        if (rw) begin
                            state  <= TX_BYTE;
                            shreg  <= duty[ptr];
                            sda_oe <= ~duty[ptr][7];
                        end else begin
                            state  <= RX_BYTE;
                            first  <= 1'b1;
                            sda_oe <= 1'b0;
                        end
                    end
                end
                RX_BYTE: if (scl_rise) begin
                    shreg   <= {shreg[6:0], sda_in};
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        state <= ACK_RX;
                        if (first) begin
                            ptr   <= {shreg[1:0], sda_in};
                            first <= 1'b0;
                        end else begin
                            duty[ptr] <= {shreg[6:0], sda_in};
                            ptr       <= ptr + 3'd1;
                        end
                    end
                end
                ACK_RX: if (scl_fall) begin
                    if (bit_cnt == 4'd8) begin
                        sda_oe  <= 1'b1;
                        bit_cnt <= 4'd9;
                    end else begin
                        sda_oe  <= 1'b0;
                        bit_cnt <= 4'd0;
                        state   <= RX_BYTE;
                    end
                end
                TX_BYTE: begin
                    if (scl_rise) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            state <= ACK_TX;
                            ptr   <= ptr + 3'd1;
                        end
                    end else if (scl_fall) begin
                        shreg  <= {shreg[6:0], 1'b0};
                        sda_oe <= ~shreg[6];
                    end
                end
                ACK_TX: begin
                    if (scl_fall && bit_cnt == 4'd8) begin
                        sda_oe  <= 1'b0;
                        bit_cnt <= 4'd9;
                    end else if (scl_fall) begin
                        state   <= TX_BYTE;
                        bit_cnt <= 4'd0;
                        shreg   <= duty[ptr];
                        sda_oe  <= ~duty[ptr][7];
                    end else if (scl_rise && sda_in) begin
                        state <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_pwm_slave.sv
// tb_i2c_pwm_slave: self-checking bench for i2c_pwm_slave.
// Drives an I2C master model and measures heartbeat and PWM duty.
module tb_i2c_pwm_slave;

    localparam int Q = 10;

    typedef struct {
        int ch;
        int exp_hi;
    } pv_t;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       scl   = 1'b1;
    logic       sda_m = 1'b1;
    wire        sda;
    logic       led;
    logic [7:0] leds;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int hi[8];
    int slave_low = 0;

    pullup (sda);
    assign sda = sda_m ? 1'bz : 1'b0;

    i2c_pwm_slave #(
        .I2C_ADDR(7'h28),
        .HB_DIV  (10),
        .PWM_DIV (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .scl (scl),
        .sda (sda),
        .led (led),
        .leds(leds)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sda_m && sda == 1'b0) slave_low++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic wq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_tx(input logic b, output logic s);
        sda_m = b;
        wq(Q);
        scl = 1'b1;
        wq(Q);
        s = sda;
        wq(Q);
        scl = 1'b0;
        wq(Q);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        wq(Q);
        scl = 1'b1;
        wq(Q);
        sda_m = 1'b0;
        wq(Q);
        scl = 1'b0;
        wq(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        wq(Q);
        scl = 1'b1;
        wq(Q);
        sda_m = 1'b1;
        wq(Q);
    endtask

    task automatic wr_byte(input logic [7:0] b, input int exp_ack,
                           input string nm);
        logic s;
        exp_q.push_back(exp_ack);
        for (int i = 7; i >= 0; i--) bit_tx(b[i], s);
        bit_tx(1'b1, s);
        chk(nm, int'(s), exp_q.pop_front());
    endtask

    task automatic rd_byte(input int exp, input logic nack,
                           input string nm);
        logic [7:0] r;
        logic       s;
        exp_q.push_back(exp);
        for (int i = 7; i >= 0; i--) begin
            bit_tx(1'b1, s);
            r[i] = s;
        end
        bit_tx(nack, s);
        chk(nm, int'(r), exp_q.pop_front());
    endtask

    task automatic pwm_meas();
        for (int n = 0; n < 8; n++) hi[n] = 0;
        repeat (512) begin
            @(negedge clk);
            for (int n = 0; n < 8; n++) if (leds[n]) hi[n]++;
        end
    endtask

    initial begin
        pv_t tab0[5];
        pv_t tab1[3];
        int  snap;
        logic s;

        tab0[0] = '{0, 2};
        tab0[1] = '{1, 40};
        tab0[2] = '{3, 120};
        tab0[3] = '{5, 200};
        tab0[4] = '{7, 510};
        tab1[0] = '{2, 256};
        tab1[1] = '{3, 0};
        tab1[2] = '{7, 510};

        wq(3);
        chk("rst_led", int'(led), 0);
        chk("rst_leds", int'(leds), 0);
        chk("rst_sda", int'(sda), 1);
        rst = 1'b0;

        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            chk("hb_led", int'(led), (k / 5) % 2);
        end

        wq(600);
        pwm_meas();
        for (int i = 0; i < 5; i++)
            chk($sformatf("pwm_rst_ch%0d", tab0[i].ch),
                hi[tab0[i].ch], tab0[i].exp_hi);

        i2c_start();
        wr_byte(8'h50, 0, "w_ack_addr");
        wr_byte(8'h02, 0, "w_ack_ptr");
        wr_byte(8'h80, 0, "w_ack_d0");
        wr_byte(8'h00, 0, "w_ack_d1");
        i2c_stop();
        wq(600);
        pwm_meas();
        for (int i = 0; i < 3; i++)
            chk($sformatf("pwm_wr_ch%0d", tab1[i].ch),
                hi[tab1[i].ch], tab1[i].exp_hi);

        snap = slave_low;
        i2c_start();
        wr_byte(8'h52, 1, "x29_nack_addr");
        wr_byte(8'h03, 1, "x29_nack_d0");
        wr_byte(8'h11, 1, "x29_nack_d1");
        i2c_stop();
        chk("x29_sda_low", slave_low - snap, 0);

        i2c_start();
        wr_byte(8'h50, 0, "rd_ack_addr_w");
        wr_byte(8'h06, 0, "rd_ack_ptr");
        i2c_start();
        wr_byte(8'h51, 0, "rd_ack_addr_r");
        rd_byte(200, 1'b0, "rd_duty6");
        rd_byte(255, 1'b0, "rd_duty7");
        rd_byte(1, 1'b1, "rd_duty0");
        i2c_stop();

        i2c_start();
        for (int i = 7; i >= 0; i--) bit_tx(((8'h50 >> i) & 1) != 0, s);
        sda_m = 1'b1;
        wq(2);
        chk("mid_ack_low", int'(sda), 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_rel", int'(sda), 1);
        wq(3);
        rst = 1'b0;
        wq(Q);
        i2c_stop();

        i2c_start();
        wr_byte(8'h50, 0, "rr_ack_addr_w");
        wr_byte(8'h02, 0, "rr_ack_ptr");
        i2c_start();
        wr_byte(8'h51, 0, "rr_ack_addr_r");
        rd_byte(40, 1'b0, "rr_duty2");
        rd_byte(60, 1'b0, "rr_duty3");
        rd_byte(80, 1'b1, "rr_duty4");
        i2c_stop();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
